fifo_control: RTL and testbench

//  Pointer/flag controller driving the FIFO storage array (memoria): turns push/pop

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_control_if.sv | 29 ++
 rtl/fifo_flag_gen.sv | 18 +
 rtl/fifo_control.sv | 80 ++++++++
 tb/tb_fifo_control.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO sizing constants and helpers, reused by the controller and the wrapper.
package fifo_pkg;

    localparam int ADDR_W = 2;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int CNT_W  = ADDR_W + 1;

    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction

    function automatic int cnt_w_of(input int aw);
        return aw + 1;
    endfunction

endpackage

// File: rtl/fifo_control_if.sv
// Push/pop request and pointer/flag bundle between a FIFO client and fifo_control.
interface fifo_control_if #(
    parameter int address_width = 2
);
    logic                     push;
    logic                     pop;
    logic                     wr_enable;
    logic                     rd_enable;
    logic [address_width-1:0] wr_ptr;
    logic [address_width-1:0] rd_ptr;
    logic [address_width:0]   count;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic                     fifo_error;

    modport master (
        output push, pop,
        input  wr_enable, rd_enable, wr_ptr, rd_ptr, count,
        input  full, empty, almost_full, almost_empty, fifo_error
    );

    modport slave (
        input  push, pop,
        output wr_enable, rd_enable, wr_ptr, rd_ptr, count,
        output full, empty, almost_full, almost_empty, fifo_error
    );
endinterface

// File: rtl/fifo_flag_gen.sv
// Decodes the registered occupancy count into the FIFO status flags.
module fifo_flag_gen #(
    parameter int CNT_W = 3,
    parameter int DEPTH = 4,
    parameter int AF    = 3,
    parameter int AE    = 1
) (
    input  logic [CNT_W-1:0] i_count,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic             o_almost_empty
);
    assign o_full         = (i_count == CNT_W'(DEPTH));
    assign o_empty        = (i_count == '0);
    assign o_almost_full  = (i_count >= CNT_W'(AF));
    assign o_almost_empty = (i_count <= CNT_W'(AE));
endmodule

// File: rtl/fifo_control.sv
// FIFO pointer/count controller; define ERROR_STICKY_EN to latch fifo_error until reset.
module fifo_control
    import fifo_pkg::*;
#(
    parameter int address_width    = ADDR_W,
    parameter int almost_full_thr  = 3,
    parameter int almost_empty_thr = 1
) (
    input  logic           clk,
    input  logic           reset,
    fifo_control_if.slave  bus
);
    localparam int L_DEPTH = depth_of(address_width);
    localparam int L_CNT_W = cnt_w_of(address_width);

    logic [address_width-1:0] r_wr_ptr;
    logic [address_width-1:0] r_rd_ptr;
    logic [L_CNT_W-1:0]       r_count;
    logic                     r_err;

    logic w_full;
    logic w_empty;
    logic w_afull;
    logic w_aempty;
    logic w_wr_en;
    logic w_rd_en;
    logic w_err;

    fifo_flag_gen #(
        .CNT_W (L_CNT_W),
        .DEPTH (L_DEPTH),
        .AF    (almost_full_thr),
        .AE    (almost_empty_thr)
    ) u_flags (
        .i_count        (r_count),
        .o_full         (w_full),
        .o_empty        (w_empty),
        .o_almost_full  (w_afull),
        .o_almost_empty (w_aempty)
    );

    // A pop on a full FIFO frees the slot the simultaneous push takes.
    always_comb begin
        w_wr_en = reset & bus.push & (~w_full | bus.pop);
        w_rd_en = reset & bus.pop & ~w_empty;
        w_err   = (bus.push & w_full & ~bus.pop) | (bus.pop & w_empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_wr_en)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + L_CNT_W'(w_wr_en)
                               - L_CNT_W'(w_rd_en);
`ifdef ERROR_STICKY_EN
            r_err <= r_err | w_err;
`else
            r_err <= w_err;
`endif
        end
    end

    assign bus.wr_enable    = w_wr_en;
    assign bus.rd_enable    = w_rd_en;
    assign bus.wr_ptr       = r_wr_ptr;
    assign bus.rd_ptr       = r_rd_ptr;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = w_afull;
    assign bus.almost_empty = w_aempty;
    assign bus.fifo_error   = r_err;
endmodule

// File: tb/tb_fifo_control.sv
// Scoreboard bench for fifo_control with a queue-based FIFO model and a memoria stand-in.
module tb_fifo_control;
    logic clk;
    logic reset;
    logic [7:0] wdata;

    fifo_control_if #(.address_width(2)) bus();

    fifo_control #(
        .address_width    (2),
        .almost_full_thr  (3),
        .almost_empty_thr (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memoria stand-in: write on the edge, read data one cycle after rd_enable
    logic [7:0] mem [4];
    logic [7:0] rdata;
    logic       rvalid;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            if (bus.wr_enable)
                mem[bus.wr_ptr] <= wdata;
            rvalid <= bus.rd_enable;
            if (bus.rd_enable)
                rdata <= mem[bus.rd_ptr];
        end
    end

    typedef struct {
        bit wr_en;
        bit rd_en;
        int wp;
        int rp;
        int cnt;
        bit err;
    } exp_t;

    exp_t     exp_q[$];
    int       data_q[$];
    int       model_q[$];
    int       occ;
    int       wr_tot;
    int       rd_tot;
    bit       sticky;
    int       n_chk;
    int       n_fail;

    task automatic chk(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        occ = 0;
        wr_tot = 0;
        rd_tot = 0;
        sticky = 0;
        model_q.delete();
        data_q.delete();
        exp_q.delete();
    endtask

    // One request cycle: drive at negedge, apply the FIFO rules, queue expectations.
    task automatic cycle(input bit p, input bit q);
        exp_t e;
        bit aw, ar, er;
        int d;
        @(negedge clk);
        d = int'($urandom_range(0, 255));
        bus.push = p;
        bus.pop  = q;
        wdata    = 8'(d);
        ar = q && (occ > 0);
        aw = p && (occ < 4 || q);
        er = (p && occ == 4 && !q) || (q && occ == 0);
        if (ar) begin
            data_q.push_back(model_q.pop_front());
            rd_tot++;
        end
        if (aw) begin
            model_q.push_back(d);
            wr_tot++;
        end
        occ = model_q.size();
`ifdef ERROR_STICKY_EN
        sticky = sticky | er;
        e.err = sticky;
`else
        e.err = er;
`endif
        e.wr_en = aw;
        e.rd_en = ar;
        e.wp    = wr_tot % 4;
        e.rp    = rd_tot % 4;
        e.cnt   = occ;
        exp_q.push_back(e);
    endtask

    task automatic check_flags(input string tag, input int c);
        chk({tag, ".count"}, int'(bus.count), c);
        chk({tag, ".full"}, int'(bus.full), int'(c == 4));
        chk({tag, ".empty"}, int'(bus.empty), int'(c == 0));
        chk({tag, ".afull"}, int'(bus.almost_full), int'(c >= 3));
        chk({tag, ".aempty"}, int'(bus.almost_empty), int'(c <= 1));
    endtask

    // Control monitor: enables just before the edge, registered state just after.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (exp_q.size() > 0 && reset) begin
                e = exp_q.pop_front();
                chk("wr_enable", int'(bus.wr_enable), int'(e.wr_en));
                chk("rd_enable", int'(bus.rd_enable), int'(e.rd_en));
                @(posedge clk);
                #1;
                chk("wr_ptr", int'(bus.wr_ptr), e.wp);
                chk("rd_ptr", int'(bus.rd_ptr), e.rp);
                chk("fifo_error", int'(bus.fifo_error), int'(e.err));
                check_flags("st", e.cnt);
            end
        end
    end

    // Data monitor: every memoria readout must match write order.
    initial begin
        int x;
        forever begin
            @(posedge clk);
            #1;
            if (rvalid && reset) begin
                if (data_q.size() == 0) begin
                    chk("rdata_unexpected", 1, 0);
                end else begin
                    x = data_q.pop_front();
                    chk("rdata", int'(rdata), x);
                end
            end
        end
    end

    initial begin
        n_chk = 0;
        n_fail = 0;
        model_reset();
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        wdata    = '0;
        reset    = 1'b0;
        #3;
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        #1;
        chk("rst.wr_enable", int'(bus.wr_enable), 0);
        chk("rst.rd_enable", int'(bus.rd_enable), 0);
        chk("rst.wr_ptr", int'(bus.wr_ptr), 0);
        chk("rst.rd_ptr", int'(bus.rd_ptr), 0);
        chk("rst.error", int'(bus.fifo_error), 0);
        check_flags("rst", 0);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #17;
        reset = 1'b1;

        // fill, overflow, push+pop while full
        repeat (4) cycle(1, 0);
        cycle(1, 0);
        cycle(0, 0);
        cycle(1, 1);
        cycle(1, 1);
        // drain, underflow, push+pop while empty
        repeat (4) cycle(0, 1);
        cycle(0, 1);
        cycle(0, 0);
        cycle(1, 1);
        // pointer wrap at count 1
        repeat (6) cycle(1, 1);
        cycle(1, 0);
        cycle(0, 0);
        repeat (3) @(posedge clk);

        // async reset mid-run with count 2
        @(negedge clk);
        #2;
        chk("pre_rst.count", int'(bus.count), 2);
        bus.push = 1'b1;
        bus.pop  = 1'b1;
        reset    = 1'b0;
        #1;
        model_reset();
        chk("mid_rst.wr_enable", int'(bus.wr_enable), 0);
        chk("mid_rst.rd_enable", int'(bus.rd_enable), 0);
        chk("mid_rst.wr_ptr", int'(bus.wr_ptr), 0);
        chk("mid_rst.rd_ptr", int'(bus.rd_ptr), 0);
        chk("mid_rst.error", int'(bus.fifo_error), 0);
        check_flags("mid_rst", 0);
        @(posedge clk);
        #2;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        reset    = 1'b1;

        // randomized phases biased towards filling then draining
        for (int ph = 0; ph < 6; ph++) begin
            int pp;
            int pq;
            pp = (ph % 2 == 0) ? 75 : 25;
            pq = (ph % 2 == 0) ? 30 : 75;
            for (int i = 0; i < 60; i++)
                cycle($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq);
        end
        cycle(0, 0);
        repeat (4) @(posedge clk);
        chk("drain.exp_q", exp_q.size(), 0);
        chk("drain.data_q", data_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
